conv_frame_capture: RTL and testbench
=====================================

# conv_frame_capture

Receive-side counterpart of the convolution stream interface. Accepts the `valid`-qualified pixel stream produced by `convolution`, where pixels arrive row by row from the bottom-left corner to the top-right corner. Writes each pixel into an external frame RAM at its top-down raster address, so the stored frame reads out in natural row-major order. Tracks frame progress, signals completion, and flags pixels that arrive outside a capture window.

## Interface
- `WORD_SIZE`, 8, pixel width in bits
- `ROW_SIZE`, 540, pixels per row (frame width)
- `IMAGE_HEIGHT`, 360, rows per frame
- `ADDR_W`, `$clog2(ROW_SIZE*IMAGE_HEIGHT)`, RAM address width (derived localparam)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  arm a new capture (single-cycle pulse)
- `inputPixel`  in  WORD_SIZE  pixel from `convolution.outputPixel`
- `valid`  in  1  `inputPixel` is valid this cycle
- `mem_we`  out  1  RAM write enable
- `mem_addr`  out  ADDR_W  RAM write address, top-down row-major
- `mem_wdata`  out  WORD_SIZE  RAM write data
- `busy`  out  1  high in CAPTURE
- `frame_done`  out  1  one-cycle pulse coincident with the final write of a frame
- `dropped`  out  1  sticky flag: a valid pixel was seen outside CAPTURE

## Operation
- FSM states:
  - IDLE: `start` -> CAPTURE.
  - CAPTURE: the last pixel of the frame is accepted -> DONE. `start` -> CAPTURE, with counters re-initialised (abort and restart).
  - DONE: `start` -> CAPTURE.
- Entering CAPTURE:
  - col = 0, row = IMAGE_HEIGHT-1.
  - Address counter = (IMAGE_HEIGHT-1)*ROW_SIZE.
  - `dropped` cleared.
- Each accepted pixel (valid && state==CAPTURE):
  - Write `inputPixel` at the current address.
  - If col < ROW_SIZE-1: col+1, addr+1.
  - Else: col = 0, row-1, addr -= (2*ROW_SIZE-1). The next address is the start of the row above.
- Last pixel: row==0 && col==ROW_SIZE-1. Write it, pulse `frame_done`, go to DONE.
- `valid` gaps: pixels need not be contiguous. Idle cycles hold all counters.
- `valid` in IDLE or DONE: pixel is discarded, no write, `dropped` set to 1. `dropped` holds until `start` or `rst`.
- Address arithmetic:
  - Unsigned, ADDR_W bits.
  - The subtraction never underflows, because it occurs only when row ≥ 1.
  - Row counter width is `$clog2(IMAGE_HEIGHT)`; column counter width is `$clog2(ROW_SIZE)`.
- `start` and `valid` in the same cycle: the pixel is NOT captured. Capture begins with the next valid. In IDLE/DONE this pixel sets `dropped`, and the clear on `start` takes priority, so `dropped` = 0 afterwards.
- `rst` mid-frame: immediate return to IDLE, no further writes. RAM contents are left as written.

## Timing
- Reset values: state=IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `frame_done`=0, `dropped`=0.
- Write path is registered. A pixel accepted at edge N appears on `mem_we`/`mem_addr`/`mem_wdata` during cycle N+1 (latency 1).
- `frame_done` is registered and high in the same cycle as the final `mem_we`.
- `busy` drops the cycle after the last pixel is accepted.
- Sustained throughput is one pixel per clock, with no back-pressure. The upstream convolution cannot stall.
- A full frame is ROW_SIZE*IMAGE_HEIGHT accepted pixels (194400 at defaults).

## Structure
- Shared package `img_pkg`:
  - `WORD_SIZE`, `ROW_SIZE` and `IMAGE_HEIGHT` defaults.
  - `cap_state_t` enum {IDLE, CAPTURE, DONE}.
  - `pixel_t` typedef.
- Sub-module `raster_addr_gen` holds the row, column and address counters, with the bottom-up-to-top-down flip. Inputs are init/step; outputs are addr/last. It is reusable later by a matching frame source that replays the frame in bottom-up order.
- The top level holds the FSM, the write-register stage and the `dropped` flag.

## Test plan
- Small frame (ROW_SIZE=4, IMAGE_HEIGHT=3): `start`, then 12 contiguous valid pixels 0x00..0x0B -> writes at addresses 8,9,10,11,4,5,6,7,0,1,2,3. `frame_done` is high only with the write of 0x0B at addr 3.
- Same frame with random 1–3 cycle `valid` gaps -> same address/data sequence. No extra `mem_we` cycles.
- `valid` pulses in IDLE, then in DONE -> no writes and `dropped`=1. A following `start` -> `dropped`=0.
- `start` issued mid-frame after 5 pixels -> the next pixel is written at addr 8. The full 12-pixel frame completes normally.
- `start` and `valid` in the same cycle with data 0xAA -> 0xAA never written. The next valid is written at addr 8.
- Assert `rst` after 7 pixels -> outputs return to reset values on the next cycle, no writes afterwards. Re-`start` -> capture restarts at addr 8.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-pipeline types and default frame geometry.
package img_pkg;

    localparam int WORD_SIZE    = 8;
    localparam int ROW_SIZE     = 540;
    localparam int IMAGE_HEIGHT = 360;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } cap_state_t;

    typedef logic [WORD_SIZE-1:0] pixel_t;

endpackage

// File: rtl/conv_frame_capture_if.sv
// Pixel stream in from the convolution plus the frame-RAM write port out.
interface conv_frame_capture_if #(
    parameter int WORD_SIZE = 8,
    parameter int ADDR_W    = 18
);

    logic [WORD_SIZE-1:0] inputPixel;
    logic                 valid;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    // master feeds pixels and watches the RAM port; slave is the capture block
    modport master (
        output inputPixel, valid,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  inputPixel, valid,
        output mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/raster_addr_gen.sv
// Row/column/address counters walking a frame bottom-up while emitting
// top-down row-major addresses.
module raster_addr_gen
    import img_pkg::*;
#(
    parameter int ROW_SIZE     = img_pkg::ROW_SIZE,
    parameter int IMAGE_HEIGHT = img_pkg::IMAGE_HEIGHT,
    parameter int ADDR_W       = $clog2(ROW_SIZE*IMAGE_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_TOP  = ROW_W'(IMAGE_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'((IMAGE_HEIGHT - 1) * ROW_SIZE);
    localparam logic [ADDR_W-1:0] ROW_BACK = ADDR_W'(2 * ROW_SIZE - 1);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Stepping stops at the final pixel so the row counter never wraps below 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (init) begin
            col  <= '0;
            row  <= ROW_TOP;
            addr <= ADDR_TOP;
        end else if (step && !last) begin
            if (col != COL_LAST) begin
                col  <= col + COL_W'(1);
                addr <= addr + ADDR_W'(1);
            end else begin
                col  <= '0;
                row  <= row - ROW_W'(1);
                addr <= addr - ROW_BACK;
            end
        end
    end

    assign last = (row == '0) && (col == COL_LAST);

endmodule

// File: rtl/conv_frame_capture.sv
// Captures a bottom-up convolution pixel stream into a top-down frame RAM.
module conv_frame_capture
    import img_pkg::*;
#(
    parameter int WORD_SIZE    = img_pkg::WORD_SIZE,
    parameter int ROW_SIZE     = img_pkg::ROW_SIZE,
    parameter int IMAGE_HEIGHT = img_pkg::IMAGE_HEIGHT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    conv_frame_capture_if.slave  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 dropped
);

    localparam int ADDR_W = $clog2(ROW_SIZE * IMAGE_HEIGHT);

    cap_state_t        state;
    cap_state_t        next_state;
    logic              accept;
    logic              init;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_last;

    raster_addr_gen #(
        .ROW_SIZE     (ROW_SIZE),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .ADDR_W       (ADDR_W)
    ) u_addr_gen (
        .clk  (clk),
        .rst  (rst),
        .init (init),
        .step (accept),
        .addr (cur_addr),
        .last (cur_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A pixel arriving alongside start is never captured; start always re-arms.
    always_comb begin
        next_state = state;
        init       = start;
        accept     = bus.valid && (state == CAPTURE) && !start;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                if (start) begin
                    next_state = CAPTURE;
                end else if (accept && cur_last) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            frame_done    <= 1'b0;
        end else begin
            bus.mem_we <= accept;
            frame_done <= accept && cur_last;
            if (accept) begin
                bus.mem_addr  <= cur_addr;
                bus.mem_wdata <= bus.inputPixel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            dropped <= 1'b0;
        end else if (bus.valid && (state != CAPTURE)) begin
            dropped <= 1'b1;
        end
    end

    assign busy = (state == CAPTURE);

endmodule

// File: tb/tb_conv_frame_capture.sv
// Directed self-checking bench for conv_frame_capture on a 4x3 frame.
module tb_conv_frame_capture;

    localparam int WS     = 8;
    localparam int RS     = 4;
    localparam int IH     = 3;
    localparam int AW     = 4;
    localparam int NPIX   = RS * IH;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;
    logic dropped;

    conv_frame_capture_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

    conv_frame_capture #(
        .WORD_SIZE    (WS),
        .ROW_SIZE     (RS),
        .IMAGE_HEIGHT (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .dropped    (dropped)
    );

    int numCompared   = 0;
    int numMismatched = 0;
    int strayDone     = 0;

    logic [AW-1:0] addrQ [$];
    logic [WS-1:0] dataQ [$];
    logic          doneQ [$];

    int expAddr [NPIX] = '{8, 9, 10, 11, 4, 5, 6, 7, 0, 1, 2, 3};
    int gapTable [NPIX] = '{1, 2, 3, 2, 1, 3, 1, 2, 3, 1, 2, 1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write half a cycle after it is registered.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            addrQ.push_back(bus.mem_addr);
            dataQ.push_back(bus.mem_wdata);
            doneQ.push_back(frame_done);
        end else if (frame_done) begin
            strayDone++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WS-1:0] data, input int gap);
        @(negedge clk);
        bus.valid      = 1'b1;
        bus.inputPixel = data;
        repeat (gap) begin
            @(negedge clk);
            bus.valid = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid = 1'b0;
            start     = 1'b0;
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start     = 1'b1;
        bus.valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clearLog();
        addrQ.delete();
        dataQ.delete();
        doneQ.delete();
        strayDone = 0;
    endtask

    // Compare one full frame of logged writes starting at log index firstIdx.
    task automatic checkFrame(input string tag, input int firstIdx, input logic [WS-1:0] dataBase);
        for (int i = 0; i < NPIX; i++) begin
            int idx = firstIdx + i;
            logic [31:0] obsAddr = 32'hFFFF_FFFF;
            logic [31:0] obsData = 32'hFFFF_FFFF;
            logic [31:0] obsDone = 32'hFFFF_FFFF;
            if (idx < addrQ.size()) begin
                obsAddr = 32'(addrQ[idx]);
                obsData = 32'(dataQ[idx]);
                obsDone = 32'(doneQ[idx]);
            end
            checkOutput($sformatf("%s addr[%0d]", tag, i), obsAddr, 32'(expAddr[i]));
            checkOutput($sformatf("%s data[%0d]", tag, i), obsData, 32'(dataBase + WS'(i)));
            checkOutput($sformatf("%s done[%0d]", tag, i), obsDone, (i == NPIX - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        int aaCount;

        rst            = 1'b1;
        start          = 1'b0;
        bus.valid      = 1'b0;
        bus.inputPixel = '0;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(1);

        checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("reset mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset frame_done", 32'(frame_done), 32'd0);
        checkOutput("reset dropped", 32'(dropped), 32'd0);

        $display("[TB] valid while idle");
        clearLog();
        applyStimulus(8'h55, 1);
        idleCycles(2);
        checkOutput("idle dropped", 32'(dropped), 32'd1);
        checkOutput("idle writes", 32'(addrQ.size()), 32'd0);
        pulseStart();
        checkOutput("start clears dropped", 32'(dropped), 32'd0);
        checkOutput("capture busy", 32'(busy), 32'd1);

        $display("[TB] contiguous frame");
        clearLog();
        for (int i = 0; i < NPIX; i++) applyStimulus(WS'(i), 0);
        idleCycles(3);
        checkOutput("contig count", 32'(addrQ.size()), 32'(NPIX));
        checkFrame("contig", 0, 8'h00);
        checkOutput("contig stray done", 32'(strayDone), 32'd0);
        checkOutput("contig busy after", 32'(busy), 32'd0);
        checkOutput("contig dropped", 32'(dropped), 32'd0);

        $display("[TB] valid while done");
        clearLog();
        applyStimulus(8'h66, 1);
        idleCycles(2);
        checkOutput("done dropped", 32'(dropped), 32'd1);
        checkOutput("done writes", 32'(addrQ.size()), 32'd0);
        pulseStart();
        checkOutput("restart clears dropped", 32'(dropped), 32'd0);

        $display("[TB] frame with valid gaps");
        clearLog();
        for (int i = 0; i < NPIX; i++) applyStimulus(8'h80 + WS'(i), gapTable[i]);
        idleCycles(3);
        checkOutput("gap count", 32'(addrQ.size()), 32'(NPIX));
        checkFrame("gap", 0, 8'h80);
        checkOutput("gap stray done", 32'(strayDone), 32'd0);

        $display("[TB] restart mid-frame");
        clearLog();
        pulseStart();
        for (int i = 0; i < 5; i++) applyStimulus(8'h20 + WS'(i), 0);
        pulseStart();
        for (int i = 0; i < NPIX; i++) applyStimulus(8'h40 + WS'(i), 0);
        idleCycles(3);
        checkOutput("restart count", 32'(addrQ.size()), 32'(NPIX + 5));
        checkOutput("restart pre addr4", (addrQ.size() > 4) ? 32'(addrQ[4]) : 32'hFFFF_FFFF, 32'd4);
        checkFrame("restart", 5, 8'h40);
        checkOutput("restart stray done", 32'(strayDone), 32'd0);

        $display("[TB] start and valid together");
        clearLog();
        @(negedge clk);
        start          = 1'b1;
        bus.valid      = 1'b1;
        bus.inputPixel = 8'hAA;
        @(negedge clk);
        start     = 1'b0;
        bus.valid = 1'b0;
        checkOutput("collide dropped", 32'(dropped), 32'd0);
        for (int i = 0; i < NPIX; i++) applyStimulus(8'h30 + WS'(i), 0);
        idleCycles(3);
        aaCount = 0;
        foreach (dataQ[i]) if (dataQ[i] == 8'hAA) aaCount++;
        checkOutput("collide 0xAA writes", 32'(aaCount), 32'd0);
        checkOutput("collide count", 32'(addrQ.size()), 32'(NPIX));
        checkFrame("collide", 0, 8'h30);

        $display("[TB] reset mid-frame");
        clearLog();
        pulseStart();
        for (int i = 0; i < 7; i++) applyStimulus(8'h60 + WS'(i), 0);
        @(negedge clk);
        bus.valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst mem_addr", 32'(bus.mem_addr), 32'd0);
        checkOutput("rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst frame_done", 32'(frame_done), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h70 + WS'(i), 0);
        idleCycles(3);
        checkOutput("rst writes", 32'(addrQ.size()), 32'd7);
        checkOutput("rst last addr", (addrQ.size() > 6) ? 32'(addrQ[6]) : 32'hFFFF_FFFF, 32'd6);
        pulseStart();
        applyStimulus(8'h77, 0);
        idleCycles(3);
        checkOutput("rerun count", 32'(addrQ.size()), 32'd8);
        checkOutput("rerun addr", (addrQ.size() > 7) ? 32'(addrQ[7]) : 32'hFFFF_FFFF, 32'd8);
        checkOutput("rerun data", (dataQ.size() > 7) ? 32'(dataQ[7]) : 32'hFFFF_FFFF, 32'h77);
        checkOutput("rerun busy", 32'(busy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
